// File: rtl/rcas_3_checker.sv
// Sweep checker for a 3-bit ripple-carry adder/subtractor.
// Drives all 128 {con, A, B} vectors, compares S/Cout to a golden model, and records the results.
module rcas_3_checker #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       halt_on_fail,
  input  logic [2:0] S,
  input  logic       Cout,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       con,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       fail_valid,
  output logic [6:0] first_fail
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_halt;
  logic [2:0] r_a;
  logic [2:0] r_b;
  logic       r_con;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [7:0] r_err;
  logic       r_fail_valid;
  logic [6:0] r_first_fail;

  logic [6:0] w_idx;
  logic [3:0] w_golden;
  logic       w_mismatch;
  logic [7:0] w_err_next;
  logic       w_last;

  // Subtract is A + ~B + 1 kept to 4 bits, so bit 3 is the borrow-free carry.
  function automatic logic [3:0] golden(input logic [6:0] idx);
    logic [3:0] a4;
    logic [3:0] b4;
    a4 = {1'b0, idx[5:3]};
    b4 = {1'b0, idx[2:0]};
    if (idx[6])
      return a4 + {1'b0, ~idx[2:0]} + 4'd1;
    else
      return a4 + b4;
  endfunction

  assign w_idx      = {r_con, r_a, r_b};
  assign w_golden   = golden(w_idx);
  assign w_mismatch = ({Cout, S} != w_golden);
  assign w_err_next = r_err + {7'd0, w_mismatch};
  assign w_last     = (w_idx == 7'd127) || (w_mismatch && r_halt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_halt       <= 1'b0;
      r_a          <= 3'd0;
      r_b          <= 3'd0;
      r_con        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= 8'd0;
      r_fail_valid <= 1'b0;
      r_first_fail <= 7'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_SETTLE;
            r_cnt        <= 4'd0;
            r_halt       <= halt_on_fail;
            r_a          <= 3'd0;
            r_b          <= 3'd0;
            r_con        <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= 8'd0;
            r_fail_valid <= 1'b0;
            r_first_fail <= 7'd0;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == 4'(SETTLE - 1))
            r_state <= ST_CHECK;
          else
            r_cnt <= r_cnt + 4'd1;
        end
        ST_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_first_fail <= w_idx;
          end
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 8'd0);
          end else begin
            r_state              <= ST_SETTLE;
            r_cnt                <= 4'd0;
            {r_con, r_a, r_b}    <= w_idx + 7'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign A          = r_a;
  assign B          = r_b;
  assign con        = r_con;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign first_fail = r_first_fail;

endmodule

// File: tb/tb_rcas_3_checker.sv
// Randomized scoreboard bench for rcas_3_checker with a fault-injectable adder model.
module tb_rcas_3_checker;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       halt_on_fail;
  logic [2:0] S;
  logic       Cout;
  logic [2:0] A;
  logic [2:0] B;
  logic       con;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic       fail_valid;
  logic [6:0] first_fail;

  logic [1:0] fault_mode = 2'd0;
  logic [6:0] fault_tgt  = 7'd0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         last;
    int         errs;
    logic       fv;
    logic [6:0] ff;
    int         start_edge;
  } exp_t;

  exp_t q[$];

  rcas_3_checker #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_on_fail(halt_on_fail),
    .S(S), .Cout(Cout), .A(A), .B(B), .con(con), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_valid(fail_valid), .first_fail(first_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder under test: 0 good, 1 S[0] stuck at 0, 2 Cout inverted in subtract, 3 S[2] flipped at one vector.
  function automatic logic [3:0] model_adder(input logic [2:0] a, input logic [2:0] b, input logic c,
                                             input logic [1:0] m, input logic [6:0] t);
    logic [4:0] r;
    logic [3:0] o;
    r = c ? ({2'b0, a} + {2'b0, ~b} + 5'd1) : ({2'b0, a} + {2'b0, b});
    o = r[3:0];
    case (m)
      2'd1: o[0] = 1'b0;
      2'd2: if (c) o[3] = ~o[3];
      2'd3: if ({c, a, b} == t) o[2] = ~o[2];
      default: ;
    endcase
    return o;
  endfunction

  assign {Cout, S} = model_adder(A, B, con, fault_mode, fault_tgt);

  function automatic exp_t ref_sweep(input logic halt, input logic [1:0] m, input logic [6:0] t);
    exp_t e;
    e.last = 127; e.errs = 0; e.fv = 1'b0; e.ff = 7'd0; e.start_edge = 0;
    for (int i = 0; i < 128; i++) begin
      int a, b, c, gs, gc;
      logic [3:0] obs;
      a = (i >> 3) & 7; b = i & 7; c = (i >> 6) & 1;
      if (c == 0) begin gs = (a + b) % 8; gc = (a + b) / 8; end
      else begin gs = (a - b + 8) % 8; gc = (a >= b) ? 1 : 0; end
      obs = model_adder(3'(a), 3'(b), 1'(c), m, t);
      if (int'(obs[2:0]) != gs || int'(obs[3]) != gc) begin
        e.errs++;
        if (!e.fv) begin e.fv = 1'b1; e.ff = 7'(i); end
        if (halt) begin e.last = i; break; end
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_A"}, A, 0);             check({tag, "_B"}, B, 0);
    check({tag, "_con"}, con, 0);         check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);       check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);   check({tag, "_fv"}, fail_valid, 0);
    check({tag, "_ff"}, first_fail, 0);
  endtask

  // Monitor: each rising done is matched against the oldest outstanding expectation.
  logic prev_done = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("latency", cyc - e.start_edge + 1, (e.last + 1) * (SETTLE + 1) + 1);
          check("busy_at_done", busy, 0);
          check("pass", pass, (e.errs == 0) ? 1 : 0);
          check("err_count", err_count, e.errs);
          check("fail_valid", fail_valid, e.fv);
          check("first_fail", first_fail, e.ff);
          check("final_vec", {con, A, B}, e.last);
        end
      end
      prev_done = done;
    end
  end

  task automatic issue_start(input logic halt);
    @(negedge clk);
    halt_on_fail = halt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    halt_on_fail = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    check("err_cleared", err_count, 0);
    check("fv_cleared", fail_valid, 0);
    check("vec0", {con, A, B}, 0);
  endtask

  task automatic run_sweep(input logic [1:0] m, input logic [6:0] t, input logic halt, input logic noisy);
    exp_t e;
    bit   seen;
    @(negedge clk);
    fault_mode = m;
    fault_tgt  = t;
    e = ref_sweep(halt, m, t);
    e.start_edge = cyc + 2;
    q.push_back(e);
    issue_start(halt);
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin seen = 1'b1; break; end
      start = noisy && ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt_on_fail = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    run_sweep(2'd0, 7'd0, 1'b0, 1'b0);
    run_sweep(2'd1, 7'd0, 1'b0, 1'b0);
    run_sweep(2'd2, 7'd0, 1'b0, 1'b0);
    run_sweep(2'd1, 7'd0, 1'b1, 1'b1);
    run_sweep(2'd0, 7'd0, 1'b0, 1'b1);

    // Abort a sweep with rst at its 200th edge; nothing is expected from it.
    begin
      int s_edge;
      fault_mode = 2'd1;
      s_edge = cyc + 2;
      issue_start(1'b0);
      while (cyc < s_edge + 199) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("abort");
      rst = 1'b0;
    end
    run_sweep(2'd0, 7'd0, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++)
      run_sweep(2'd3, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'b1);
    run_sweep(2'd0, 7'd0, 1'($urandom_range(0, 1)), 1'b1);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
